// File: rtl/splicer_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the splicer AXI4-Stream input.
// Regenerates tuser/tlast from its own counters and zero-pads frames cut short by an early SOF.
module splicer_frame_arbiter #(
    parameter int DATA_WIDTH   = 48,
    parameter int FRAME_WIDTH  = 64,
    parameter int FRAME_HEIGHT = 48
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tuser,
    input  logic                  s0_axis_tlast,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tuser,
    input  logic                  s1_axis_tlast,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,

    output logic                  m_src,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int BEATS_PER_LINE = FRAME_WIDTH / 2;
    localparam int CW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(BEATS_PER_LINE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          sel_q, sel_d;
    logic          last_grant_q, last_grant_d;
    logic          m_src_q, m_src_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0] sel_tdata;
    logic                  sel_tvalid;
    logic                  sel_tuser;
    logic                  sel_tlast;
    logic                  sel_tready;
    logic                  col_last;
    logic                  row_last;
    logic                  at_sof;
    logic                  advance;
    logic                  req0;
    logic                  req1;
    logic                  grant;

    assign sel_tdata  = sel_q ? s1_axis_tdata  : s0_axis_tdata;
    assign sel_tvalid = sel_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_tuser  = sel_q ? s1_axis_tuser  : s0_axis_tuser;
    assign sel_tlast  = sel_q ? s1_axis_tlast  : s0_axis_tlast;

    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign at_sof   = (col_q == '0) && (row_q == '0);

    // AXI4-Stream: a beat transfers on a cycle where tvalid && tready; once tvalid
    // is raised it stays high with stable tdata until that transfer happens.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        sel_d          = sel_q;
        last_grant_d   = last_grant_q;
        m_src_d        = m_src_q;
        frame_done_d   = 1'b0;
        frame_err_d    = 1'b0;
        advance        = 1'b0;
        sel_tready     = 1'b0;
        req0           = 1'b0;
        req1           = 1'b0;
        grant          = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tuser   = 1'b0;
        m_axis_tlast   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req0 = s0_axis_tvalid && s0_axis_tuser;
                req1 = s1_axis_tvalid && s1_axis_tuser;
                // Stray mid-frame beats are swallowed; SOF beats are held for the grant.
                s0_axis_tready = !s0_axis_tuser;
                s1_axis_tready = !s1_axis_tuser;
                if (req0 || req1) begin
                    grant   = (req0 && req1) ? !last_grant_q : req1;
                    sel_d   = grant;
                    m_src_d = grant;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (sel_tvalid && sel_tuser && !at_sof) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_FLUSH;
                end else begin
                    m_axis_tdata  = sel_tdata;
                    m_axis_tvalid = sel_tvalid;
                    m_axis_tuser  = at_sof;
                    m_axis_tlast  = col_last;
                    sel_tready    = m_axis_tready;
                    if (sel_tvalid && m_axis_tready) begin
                        advance = 1'b1;
                        if (sel_tlast != col_last) begin
                            frame_err_d = 1'b1;
                        end
                        if (col_last && row_last) begin
                            frame_done_d = 1'b1;
                            last_grant_d = sel_q;
                            state_d      = ST_IDLE;
                        end
                    end
                end
                s0_axis_tready = !sel_q && sel_tready;
                s1_axis_tready = sel_q && sel_tready;
            end
            ST_FLUSH: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = col_last;
                if (m_axis_tready) begin
                    advance = 1'b1;
                    if (col_last && row_last) begin
                        frame_done_d = 1'b1;
                        last_grant_d = sel_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // Nothing may be accepted or offered while reset is held.
        if (!aresetn) begin
            s0_axis_tready = 1'b0;
            s1_axis_tready = 1'b0;
            m_axis_tvalid  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            m_src_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            m_src_q      <= m_src_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign m_src      = m_src_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_splicer_frame_arbiter.sv
// Bench for splicer_frame_arbiter on an 8x4 frame (4 beats/line, 16 beats/frame).
// Expected beats are queued as {src, tuser, tlast, tdata}; a forked monitor pops them.
module tb_splicer_frame_arbiter;

    localparam int DW  = 48;
    localparam int FW  = 8;
    localparam int FH  = 4;
    localparam int BPL = FW / 2;
    localparam int FB  = BPL * FH;
    localparam int W   = DW + 3;

    logic          aclk;
    logic          aresetn;
    logic [DW-1:0] s0_axis_tdata;
    logic          s0_axis_tvalid;
    logic          s0_axis_tready;
    logic          s0_axis_tuser;
    logic          s0_axis_tlast;
    logic [DW-1:0] s1_axis_tdata;
    logic          s1_axis_tvalid;
    logic          s1_axis_tready;
    logic          s1_axis_tuser;
    logic          s1_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_src;
    logic          frame_done;
    logic          frame_err;

    splicer_frame_arbiter #(
        .DATA_WIDTH  (DW),
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tready(s0_axis_tready),
        .s0_axis_tuser (s0_axis_tuser),
        .s0_axis_tlast (s0_axis_tlast),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tready(s1_axis_tready),
        .s1_axis_tuser (s1_axis_tuser),
        .s1_axis_tlast (s1_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_src         (m_src),
        .frame_done    (frame_done),
        .frame_err     (frame_err)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish within 2 ms");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           checks;
    int           errors;
    int           done_cnt;
    int           err_cnt;
    int           done_exp;
    int           err_exp;
    int           bubble_cnt;
    bit           count_bubbles;
    bit           rand_ready;

    function automatic logic [DW-1:0] pix(input int src, input int f, input int b);
        logic [DW-1:0] p;
        p        = 48'hA000_0000_0000;
        p[39:32] = src[7:0];
        p[31:16] = f[15:0];
        p[15:0]  = b[15:0];
        return p;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Queue one frame; beats at index >= pad_from are expected as zero padding.
    task automatic push_frame(input int src, input int f, input int pad_from, input int count);
        for (int b = 0; b < count; b++) begin
            if (b >= pad_from)
                exp_q.push_back({src[0], 1'b0, (b % BPL) == BPL - 1, {DW{1'b0}}});
            else
                exp_q.push_back({src[0], b == 0, (b % BPL) == BPL - 1, pix(src, f, b)});
        end
    endtask

    // ---------------- monitor ----------------
    task automatic monitor();
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        logic          prev_done  = 1'b0;
        logic          prev_err   = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (prev_stall) begin
                    check("hold_valid", {2'b0, m_axis_tvalid, m_axis_tdata}, {2'b0, 1'b1, prev_data});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h, expected no output",
                                 {m_src, m_axis_tuser, m_axis_tlast, m_axis_tdata});
                    end else begin
                        check("beat", {m_src, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                              exp_q.pop_front());
                    end
                end
                if (count_bubbles && !m_axis_tvalid && exp_q.size() > 0) bubble_cnt++;
            end
            if (frame_done) begin
                done_cnt++;
                if (prev_done) begin
                    checks++;
                    errors++;
                    $display("FAIL done_pulse: got 2-cycle frame_done, expected 1 cycle");
                end
            end
            if (frame_err) begin
                err_cnt++;
                if (prev_err) begin
                    checks++;
                    errors++;
                    $display("FAIL err_pulse: got 2-cycle frame_err, expected 1 cycle");
                end
            end
            prev_done  = frame_done;
            prev_err   = frame_err;
            prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_beat(input int src, input logic [DW-1:0] d, input logic u, input logic l);
        int  n;
        logic rdy;
        if (src == 0) begin
            s0_axis_tdata = d; s0_axis_tuser = u; s0_axis_tlast = l; s0_axis_tvalid = 1'b1;
        end else begin
            s1_axis_tdata = d; s1_axis_tuser = u; s1_axis_tlast = l; s1_axis_tvalid = 1'b1;
        end
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 300) begin
            @(negedge aclk);
            rdy = (src == 0) ? s0_axis_tready : s1_axis_tready;
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL src%0d_ready_timeout: got no tready in 300 cycles, expected accept", src);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_src(input int src);
        if (src == 0) s0_axis_tvalid = 1'b0;
        else          s1_axis_tvalid = 1'b0;
    endtask

    // Sends beats 0..FB-1; stops before beat 'trunc' leaving the last beat presented.
    task automatic send_frame(input int src, input int f, input int trunc, input int tlast_bad);
        for (int b = 0; b < FB; b++) begin
            if (b == trunc) return;
            drive_beat(src, pix(src, f, b), b == 0, ((b % BPL) == BPL - 1) || (b == tlast_bad));
        end
        idle_src(src);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        check({nm, "_drain"}, W'(exp_q.size()), W'(0));
        exp_q.delete();
        repeat (3) @(negedge aclk);
        check({nm, "_done_count"}, W'(done_cnt), W'(done_exp));
        check({nm, "_err_count"}, W'(err_cnt), W'(err_exp));
    endtask

    task automatic reset_pulse();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0; errors = 0; done_cnt = 0; err_cnt = 0; done_exp = 0; err_exp = 0;
        bubble_cnt = 0; count_bubbles = 1'b0; rand_ready = 1'b0;
        aresetn = 1'b0; m_axis_tready = 1'b1;
        s0_axis_tdata = '0; s0_axis_tvalid = 1'b0; s0_axis_tuser = 1'b0; s0_axis_tlast = 1'b0;
        s1_axis_tdata = '0; s1_axis_tvalid = 1'b0; s1_axis_tuser = 1'b0; s1_axis_tlast = 1'b0;
        fork
            monitor();
            ready_gen();
        join_none

        // Reset: an SOF on s0 and a stray beat on s1 must see no tready and no output.
        s0_axis_tvalid = 1'b1; s0_axis_tuser = 1'b1; s0_axis_tdata = pix(0, 7, 7);
        s1_axis_tvalid = 1'b1; s1_axis_tuser = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_tvalid", W'(m_axis_tvalid), W'(0));
        check("rst_s0_tready", W'(s0_axis_tready), W'(0));
        check("rst_s1_tready", W'(s1_axis_tready), W'(0));
        check("rst_done_err_src", W'({frame_done, frame_err, m_src}), W'(0));
        @(posedge aclk);
        #1;
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; s0_axis_tuser = 1'b0;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // 1: single s0 frame, sink always ready.
        push_frame(0, 0, FB, FB);
        send_frame(0, 0, -1, -1);
        done_exp += 1;
        drain("t1");

        // 2: both sources contend from reset, three frames each, strict alternation.
        reset_pulse();
        for (int f = 0; f < 3; f++) begin
            push_frame(0, f + 1, FB, FB);
            push_frame(1, f, FB, FB);
        end
        bubble_cnt = 0;
        count_bubbles = 1'b1;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(0, f + 1, -1, -1);
            end
            begin
                for (int f = 0; f < 3; f++) send_frame(1, f, -1, -1);
            end
        join
        done_exp += 6;
        drain("t2");
        count_bubbles = 1'b0;
        // One IDLE cycle before the first frame and one between each pair of frames.
        check("t2_bubbles", W'(bubble_cnt), W'(6));

        // 3: random sink backpressure on an s1 frame.
        rand_ready = 1'b1;
        push_frame(1, 10, FB, FB);
        send_frame(1, 10, -1, -1);
        done_exp += 1;
        drain("t3");
        rand_ready = 1'b0;
        @(posedge aclk);
        #1;

        // 4: s1 restarts at beat 6; beats 6..15 padded with zero, then the new frame.
        push_frame(1, 20, 6, FB);
        push_frame(1, 21, FB, FB);
        send_frame(1, 20, 6, -1);
        send_frame(1, 21, -1, -1);
        done_exp += 2;
        err_exp  += 1;
        drain("t4");

        // 5: stray beats in IDLE are swallowed; then a frame with an early source tlast.
        for (int i = 0; i < 5; i++) drive_beat(0, pix(0, 99, i), 1'b0, 1'b0);
        idle_src(0);
        push_frame(0, 30, FB, FB);
        send_frame(0, 30, -1, -1);
        push_frame(0, 31, FB, FB);
        send_frame(0, 31, -1, 2);
        done_exp += 2;
        err_exp  += 1;
        drain("t5");

        // 6: reset for one cycle while beat 9 is presented.
        push_frame(0, 40, FB, 9);
        send_frame(0, 40, 9, -1);
        s0_axis_tdata = pix(0, 40, 9); s0_axis_tuser = 1'b0; s0_axis_tlast = 1'b0;
        aresetn = 1'b0;
        @(negedge aclk);
        check("t6_rst_m_tvalid", W'(m_axis_tvalid), W'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("t6_post_m_tvalid", W'(m_axis_tvalid), W'(0));
        check("t6_post_drop_ready", W'(s0_axis_tready), W'(1));
        check("t6_post_src", W'(m_src), W'(0));
        @(posedge aclk);
        #1;
        idle_src(0);
        push_frame(0, 41, FB, FB);
        send_frame(0, 41, -1, -1);
        done_exp += 1;
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/splicer_frame_arbiter.md
Name: splicer_frame_arbiter

Overview:
Frame-granular arbiter that shares the single splicer AXI4-Stream input between two video sources, s0 and s1. Grants are made only at start-of-frame, using round-robin between the two sources. The block regenerates end-of-line from its own beat/line counters and enforces frame geometry. A frame whose source restarts early is zero-padded to full size, so the downstream splicer always sees exactly FRAME_WIDTH x FRAME_HEIGHT pixels per frame.

Parameters:
DATA_WIDTH, 48, beat width; each beat is 2 pixels of 24 bits
FRAME_WIDTH, 64, pixels per line; must be even
FRAME_HEIGHT, 48, lines per frame
BEATS_PER_LINE (localparam), FRAME_WIDTH/2, beats per line

Ports:
aclk  in  1  clock
aresetn  in  1  reset
s0_axis_tdata  in  DATA_WIDTH  source 0 pixel pair
s0_axis_tvalid  in  1  source 0 valid
s0_axis_tready  out  1  source 0 ready
s0_axis_tuser  in  1  source 0 start-of-frame
s0_axis_tlast  in  1  source 0 end-of-line (checked only, not forwarded)
s1_axis_*  same as s0  source 1
m_axis_tdata  out  DATA_WIDTH  to splicer
m_axis_tvalid  out  1  to splicer
m_axis_tready  in  1  from splicer
m_axis_tuser  out  1  start-of-frame, first beat only
m_axis_tlast  out  1  end-of-line, generated from counters
m_src  out  1  source of current/last granted frame
frame_done  out  1  one-cycle pulse, frame completed (normal or padded)
frame_err  out  1  one-cycle pulse, geometry violation detected

Behaviour:
- Reset: synchronous, active-low aresetn on aclk. Applies in any state, including mid-frame.
  - State to IDLE; col and row counters to 0; last_grant to 1, so s0 wins the first tie.
  - m_src, frame_done and frame_err to 0.
  - While aresetn is low, all tready outputs and m_axis_tvalid are 0.
- Counters: col counts 0..BEATS_PER_LINE-1; row counts 0..FRAME_HEIGHT-1. Both advance only on an m_axis handshake (tvalid && tready).
  - col wraps to 0 at the last beat of a line; row then increments.
- State IDLE:
  - A source requests when its tvalid && tuser.
  - A non-SOF beat (tvalid && !tuser) is dropped: that source's tready is 1 and nothing is output.
  - A requesting source's tready is 0 in IDLE.
  - m_axis_tvalid is 0.
  - One requester: grant it. Both requesting: grant the source != last_grant.
  - On grant, register sel and m_src, then go to GRANT. One bubble cycle per frame.
- State GRANT: zero-latency combinational pass-through from the selected source.
  - m_axis_tdata = sel tdata; m_axis_tvalid = sel tvalid; sel tready = m_axis_tready; other source tready = 0.
  - m_axis_tuser = 1 only when col == 0 and row == 0.
  - m_axis_tlast = (col == BEATS_PER_LINE-1).
- Geometry checks in GRANT:
  - Source tlast on a handshaked beat with col != last: frame_err pulses the next cycle. The beat is forwarded; the generated tlast stays authoritative.
  - Missing source tlast at col == last: frame_err pulses; the beat is forwarded.
  - sel tvalid && tuser while (col, row) != (0, 0): that beat is not accepted (sel tready = 0). frame_err pulses; go to FLUSH.
  - Handshake at col == last and row == last: go to IDLE. frame_done pulses the next cycle; last_grant <= sel.
- State FLUSH: pads out the truncated frame.
  - m_axis_tvalid = 1; tdata = 0; tuser = 0; tlast per counters.
  - Both source treadys are 0.
  - On handshake of the final beat: frame_done pulse, last_grant <= sel, go to IDLE.
  - The pending SOF from the preempted source is then arbitrated normally.
- Backpressure: m_axis_tvalid must stay asserted once raised until handshake, in GRANT (inherited from the source) and in FLUSH. No beat is lost or duplicated.
- Simultaneous events in IDLE: a dropped non-SOF beat on one source and a SOF on the other in the same cycle is legal. The drop occurs and the grant proceeds.
- frame_done and frame_err are registered single-cycle pulses, never stretched. Both may assert in the same cycle.

Test Plan:
Bench parameters: FRAME_WIDTH=8, FRAME_HEIGHT=4, giving 4 beats/line and 16 beats/frame.
1. s0 sends one 16-beat frame, sink always ready -> 16 output beats, tuser on beat 0, tlast on beats 3/7/11/15, m_src=0, frame_done pulses once, frame_err stays 0.
2. s0 and s1 both assert SOF after reset, three frames each -> output frame order s0, s1, s0, s1, s0, s1; one idle bubble between frames.
3. m_axis_tready random 50% during an s1 frame -> output data matches the s1 sequence beat for beat; tvalid never drops before handshake.
4. s1 asserts tuser on beat 6 -> frame_err pulse; beats 6..15 output as zero with tlast on 7/11/15; frame_done; then the new s1 frame starts with tuser.
5. s0 streams 5 non-SOF beats while IDLE, then SOF -> the 5 beats are consumed with no output; the frame starts at the SOF beat. Separately, s0 tlast on beat 2 -> frame_err, output tlast still on beat 3.
6. aresetn low for 1 cycle at beat 9 -> m_axis_tvalid=0 and counters=0 the next cycle; the next SOF is granted with tuser on beat 0.
